// File: rtl/fpga_config_writer.sv
// fpga_config_writer: serializes the active connection table into the binary
// image parsed by fpga_config_reader. The image is a 16-byte header
// {MAGIC, VERSION, count, timestamp} followed by one 40-byte record per connection.
// Words are 32-bit little-endian and go to consecutive byte addresses from BASE_ADDR.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_write           run request, accepted in IDLE/DONE/ERR
//   cfg_connections       record count, latched on accept
//   cfg_timestamp         header word 3, latched on accept
//   busy, done            run in progress / sticky completion
//   write_error           sticky flag: count exceeded MAX_CONNECTIONS
//   words_written         accepted memory writes in the current run
//   mem_addr/wdata/we     registered write port, completes when mem_ready is high
//   mem_ready             write acceptance
//   src_req/src_index     table fetch request for one entry
//   src_ack, src_*        entry fields, valid on the ack cycle
module fpga_config_writer #(
  parameter int unsigned           MAX_CONNECTIONS = 64,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,  // only 32 is supported
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter logic [31:0]           MAGIC           = 32'h46504741,
  parameter logic [31:0]           VERSION         = 32'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_write,
  input  logic [31:0]           cfg_connections,
  input  logic [31:0]           cfg_timestamp,
  output logic                  busy,
  output logic                  done,
  output logic                  write_error,
  output logic [15:0]           words_written,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  src_req,
  output logic [5:0]            src_index,
  input  logic                  src_ack,
  input  logic [31:0]           src_switch_id,
  input  logic [31:0]           src_host_id,
  input  logic [31:0]           src_my_ip,
  input  logic [31:0]           src_peer_ip,
  input  logic [15:0]           src_my_port,
  input  logic [15:0]           src_peer_port,
  input  logic [15:0]           src_my_qp,
  input  logic [15:0]           src_peer_qp,
  input  logic [47:0]           src_my_mac,
  input  logic [47:0]           src_peer_mac,
  input  logic                  src_up
);

  typedef enum logic [2:0] {StIdle, StHdr, StFetch, StRec, StDone, StErr} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              word_q, word_d;    // word currently presented on the port
  logic [5:0]              idx_q, idx_d;
  logic [31:0]             count_q, count_d;
  logic [31:0]             ts_q, ts_d;
  logic [9:0][31:0]        rec_q, rec_d;      // record image captured on src_ack
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    req_q, req_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [15:0]             words_q, words_d;

  logic [9:0][31:0]        src_img;
  logic [3:0][31:0]        hdr_img;
  logic [3:0]              next_w;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    wr_accept;

  // Record layout as stored in memory, one entry per 32-bit word.
  assign src_img[0] = src_switch_id;
  assign src_img[1] = src_host_id;
  assign src_img[2] = src_my_ip;
  assign src_img[3] = src_peer_ip;
  assign src_img[4] = {src_peer_port, src_my_port};
  assign src_img[5] = {src_peer_qp, src_my_qp};
  assign src_img[6] = src_my_mac[31:0];
  assign src_img[7] = {src_peer_mac[15:0], src_my_mac[47:32]};
  assign src_img[8] = src_peer_mac[47:16];
  assign src_img[9] = {31'b0, src_up};

  assign hdr_img[0] = MAGIC;
  assign hdr_img[1] = VERSION;
  assign hdr_img[2] = count_q;
  assign hdr_img[3] = ts_q;

  assign next_w    = word_q + 4'd1;
  // The image is contiguous, so every word lands 4 bytes after the previous one.
  assign next_addr = addr_q + ADDR_WIDTH'(4);
  assign wr_accept = we_q & mem_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    ts_d    = ts_q;
    rec_d   = rec_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;

    if (wr_accept) begin
      words_d = words_q + 16'd1;
    end

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_write) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          count_d = cfg_connections;
          ts_d    = cfg_timestamp;
          idx_d   = '0;
          if (cfg_connections > MAX_CONNECTIONS) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StHdr;
            word_d  = '0;
            we_d    = 1'b1;
            addr_d  = BASE_ADDR;
            wdata_d = DATA_WIDTH'(MAGIC);
          end
        end
      end

      StHdr: begin
        if (wr_accept) begin
          if (word_q == 4'd3) begin
            we_d = 1'b0;
            if (count_q == 32'd0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StFetch;
              req_d   = 1'b1;
              idx_d   = '0;
            end
          end else begin
            word_d  = next_w;
            addr_d  = next_addr;
            wdata_d = DATA_WIDTH'(hdr_img[next_w[1:0]]);
          end
        end
      end

      StFetch: begin
        if (req_q && src_ack) begin
          rec_d   = src_img;
          req_d   = 1'b0;
          word_d  = '0;
          state_d = StRec;
        end
      end

      StRec: begin
        if (!we_q) begin
          // First cycle after the fetch: present word 0 from the captured record.
          we_d    = 1'b1;
          addr_d  = next_addr;
          wdata_d = DATA_WIDTH'(rec_q[0]);
        end else if (mem_ready) begin
          if (word_q == 4'd9) begin
            we_d = 1'b0;
            if ({26'b0, idx_q} + 32'd1 == count_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 6'd1;
              req_d   = 1'b1;
              state_d = StFetch;
            end
          end else begin
            word_d  = next_w;
            addr_d  = next_addr;
            wdata_d = DATA_WIDTH'(rec_q[next_w]);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      ts_q    <= '0;
      rec_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      ts_q    <= ts_d;
      rec_q   <= rec_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign busy          = (state_q == StHdr) || (state_q == StFetch) || (state_q == StRec);
  assign done          = done_q;
  assign write_error   = err_q;
  assign words_written = words_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_we        = we_q;
  assign src_req       = req_q;
  assign src_index     = idx_q;

endmodule

// File: tb/tb_fpga_config_writer.sv
module tb_fpga_config_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_write = 1'b0;
  logic [31:0] cfg_connections = '0;
  logic [31:0] cfg_timestamp = '0;
  logic        busy, done, write_error;
  logic [15:0] words_written;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        src_req;
  logic [5:0]  src_index;
  logic        src_ack = 1'b0;
  logic [31:0] src_switch_id, src_host_id, src_my_ip, src_peer_ip;
  logic [15:0] src_my_port, src_peer_port, src_my_qp, src_peer_qp;
  logic [47:0] src_my_mac, src_peer_mac;
  logic        src_up;

  always #5 clk = ~clk;

  fpga_config_writer dut (
    .clk             (clk),
    .rst             (rst),
    .start_write     (start_write),
    .cfg_connections (cfg_connections),
    .cfg_timestamp   (cfg_timestamp),
    .busy            (busy),
    .done            (done),
    .write_error     (write_error),
    .words_written   (words_written),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_ready       (mem_ready),
    .src_req         (src_req),
    .src_index       (src_index),
    .src_ack         (src_ack),
    .src_switch_id   (src_switch_id),
    .src_host_id     (src_host_id),
    .src_my_ip       (src_my_ip),
    .src_peer_ip     (src_peer_ip),
    .src_my_port     (src_my_port),
    .src_peer_port   (src_peer_port),
    .src_my_qp       (src_my_qp),
    .src_peer_qp     (src_peer_qp),
    .src_my_mac      (src_my_mac),
    .src_peer_mac    (src_peer_mac),
    .src_up          (src_up)
  );

  typedef struct {
    logic [31:0] sw, host, my_ip, peer_ip;
    logic [15:0] my_port, peer_port, my_qp, peer_qp;
    logic [47:0] my_mac, peer_mac;
    logic        up;
  } entry_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  entry_t ents [64];
  vec_t   img  [24];

  int checks = 0;
  int failures = 0;

  // Table source
  always_comb begin
    src_switch_id = ents[src_index].sw;
    src_host_id   = ents[src_index].host;
    src_my_ip     = ents[src_index].my_ip;
    src_peer_ip   = ents[src_index].peer_ip;
    src_my_port   = ents[src_index].my_port;
    src_peer_port = ents[src_index].peer_port;
    src_my_qp     = ents[src_index].my_qp;
    src_peer_qp   = ents[src_index].peer_qp;
    src_my_mac    = ents[src_index].my_mac;
    src_peer_mac  = ents[src_index].peer_mac;
    src_up        = ents[src_index].up;
  end

  logic ack_always = 1'b0;
  logic rdy_rand = 1'b0;
  int   ack_delay = 0;
  int   req_wait = 0;

  always @(negedge clk) begin
    mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (ack_always) begin
      src_ack = 1'b1;
    end else if (src_req) begin
      src_ack = (req_wait >= ack_delay);
      req_wait++;
    end else begin
      src_ack  = 1'b0;
      req_wait = 0;
    end
  end

  // Memory model and bus monitors
  logic [31:0] mem [1024];
  logic        clr = 1'b0;
  int          wr_cnt = 0;
  int          we_cycles = 0;
  int          req_cycles = 0;
  int          stall_err = 0;
  logic [31:0] last_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hDEADBEEF;
    end else if (mem_we && mem_ready) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_cnt              <= wr_cnt + 1;
      last_addr           <= mem_addr;
    end
    if (mem_we) we_cycles <= we_cycles + 1;
    if (src_req) req_cycles <= req_cycles + 1;
    if (prev_stall && (mem_addr !== prev_addr || mem_wdata !== prev_data))
      stall_err <= stall_err + 1;
    prev_stall <= mem_we && !mem_ready;
    prev_addr  <= mem_addr;
    prev_data  <= mem_wdata;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Returns at the negedge following the accept edge.
  task automatic start_run(input logic [31:0] n, input logic [31:0] ts);
    @(negedge clk);
    start_write     = 1'b1;
    cfg_connections = n;
    cfg_timestamp   = ts;
    @(posedge clk);
    @(negedge clk);
    start_write = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < 24; i++)
      chk($sformatf("%s_img_%02h", tag, img[i].addr), mem[img[i].addr[11:2]], img[i].data);
  endtask

  task automatic fill_tables();
    for (int i = 0; i < 64; i++) ents[i] = '{default: '0};
    ents[0] = '{32'd1, 32'd2, 32'hC0A80001, 32'hC0A80002, 16'd4791, 16'd4792,
                16'h0011, 16'h0022, 48'h001122334455, 48'h66778899AABB, 1'b1};
    ents[1] = '{32'd3, 32'd4, 32'h0A000001, 32'h0A000002, 16'd100, 16'd200,
                16'h0333, 16'h0444, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 1'b0};
    img[0]  = '{32'h00, 32'h46504741};
    img[1]  = '{32'h04, 32'h00000001};
    img[2]  = '{32'h08, 32'h00000002};
    img[3]  = '{32'h0C, 32'h12345678};
    img[4]  = '{32'h10, 32'h00000001};
    img[5]  = '{32'h14, 32'h00000002};
    img[6]  = '{32'h18, 32'hC0A80001};
    img[7]  = '{32'h1C, 32'hC0A80002};
    img[8]  = '{32'h20, 32'h12B812B7};
    img[9]  = '{32'h24, 32'h00220011};
    img[10] = '{32'h28, 32'h22334455};
    img[11] = '{32'h2C, 32'hAABB0011};
    img[12] = '{32'h30, 32'h66778899};
    img[13] = '{32'h34, 32'h00000001};
    img[14] = '{32'h38, 32'h00000003};
    img[15] = '{32'h3C, 32'h00000004};
    img[16] = '{32'h40, 32'h0A000001};
    img[17] = '{32'h44, 32'h0A000002};
    img[18] = '{32'h48, 32'h00C80064};
    img[19] = '{32'h4C, 32'h04440333};
    img[20] = '{32'h50, 32'hA3A4A5A6};
    img[21] = '{32'h54, 32'hB5B6A1A2};
    img[22] = '{32'h58, 32'hB1B2B3B4};
    img[23] = '{32'h5C, 32'h00000000};
  endtask

  initial begin
    int cyc;
    int base_wr, base_we, base_req;

    fill_tables();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {27'b0, busy, done, write_error, mem_we, src_req}, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_idx_words", {10'b0, src_index, words_written}, 32'h0);
    rst = 1'b0;

    // Count 0: header only, src_ack held high must not trigger a fetch
    clear_mem();
    ack_always = 1'b1;
    base_wr  = wr_cnt;
    base_req = req_cycles;
    start_run(32'd0, 32'h65A1B2C3);
    wait_done(cyc);
    chk("c0_done", {31'b0, done}, 32'd1);
    chk("c0_latency", cyc, 32'd4);
    chk("c0_writes", wr_cnt - base_wr, 32'd4);
    chk("c0_words_written", {16'b0, words_written}, 32'd4);
    chk("c0_w0", mem[0], 32'h46504741);
    chk("c0_w1", mem[1], 32'h00000001);
    chk("c0_w2", mem[2], 32'h00000000);
    chk("c0_w3", mem[3], 32'h65A1B2C3);
    chk("c0_no_req", req_cycles - base_req, 32'd0);
    @(negedge clk);
    ack_always = 1'b0;

    // Count 2, ready and ack immediate; starts from DONE
    clear_mem();
    base_wr = wr_cnt;
    start_run(32'd2, 32'h12345678);
    chk("c2_words_cleared", {16'b0, words_written}, 32'd0);
    chk("c2_done_cleared", {31'b0, done}, 32'd0);
    wait_done(cyc);
    chk("c2_done", {31'b0, done}, 32'd1);
    chk("c2_latency", cyc, 32'd28);
    chk("c2_writes", wr_cnt - base_wr, 32'd24);
    chk("c2_words_written", {16'b0, words_written}, 32'd24);
    chk("c2_last_addr", last_addr, 32'h5C);
    check_image("c2");

    // Random ready, ack delayed 3 cycles: same image, stable while stalled
    clear_mem();
    rdy_rand  = 1'b1;
    ack_delay = 3;
    base_wr   = wr_cnt;
    start_run(32'd2, 32'h12345678);
    wait_done(cyc);
    chk("st_done", {31'b0, done}, 32'd1);
    chk("st_writes", wr_cnt - base_wr, 32'd24);
    chk("st_words_written", {16'b0, words_written}, 32'd24);
    chk("st_stable", stall_err, 32'd0);
    check_image("st");
    @(negedge clk);
    rdy_rand  = 1'b0;
    ack_delay = 0;

    // Count 65: error, nothing issued
    base_we  = we_cycles;
    base_req = req_cycles;
    start_run(32'd65, 32'h0);
    chk("err_flag", {31'b0, write_error}, 32'd1);
    chk("err_busy", {31'b0, busy}, 32'd0);
    chk("err_done", {31'b0, done}, 32'd0);
    repeat (5) @(negedge clk);
    chk("err_no_we", we_cycles - base_we, 32'd0);
    chk("err_no_req", req_cycles - base_req, 32'd0);
    chk("err_words", {16'b0, words_written}, 32'd0);

    // Recovery with count 1
    base_wr = wr_cnt;
    start_run(32'd1, 32'h0);
    chk("rec_err_cleared", {31'b0, write_error}, 32'd0);
    wait_done(cyc);
    chk("rec_latency", cyc, 32'd16);
    chk("rec_writes", wr_cnt - base_wr, 32'd14);
    chk("rec_words_written", {16'b0, words_written}, 32'd14);

    // start_write pulsed mid-REC is ignored
    clear_mem();
    base_wr = wr_cnt;
    start_run(32'd2, 32'h12345678);
    cyc = 0;
    while ((wr_cnt - base_wr) < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached", {31'b0, (wr_cnt - base_wr) == 12}, 32'd1);
    start_write     = 1'b1;
    cfg_connections = 32'd1;
    cfg_timestamp   = 32'h0;
    @(negedge clk);
    start_write = 1'b0;
    wait_done(cyc);
    chk("mid_done", {31'b0, done}, 32'd1);
    chk("mid_writes", wr_cnt - base_wr, 32'd24);
    check_image("mid");

    // Reset after 7 writes aborts at once
    base_wr = wr_cnt;
    start_run(32'd2, 32'h12345678);
    cyc = 0;
    while ((wr_cnt - base_wr) < 7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    #1;
    chk("abort_ctrl", {27'b0, busy, done, write_error, mem_we, src_req}, 32'h0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_wdata", mem_wdata, 32'h0);
    chk("abort_idx_words", {10'b0, src_index, words_written}, 32'h0);
    base_we = we_cycles;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_writes", wr_cnt - base_wr, 32'd7);
    chk("abort_no_we", we_cycles - base_we, 32'd0);
    chk("abort_idle", {30'b0, busy, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
